// File: rtl/siso_reg.sv
// siso_reg: serial-in/serial-out shift register used as a fixed-latency
// delay line for single-bit streams. A bit entering on si leaves on so
// exactly DEPTH rising edges later, in order. A synchronous active-low
// clear fills every stage with RESET_VALUE.
module siso_reg #(
    parameter int   DEPTH       = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic si,
    output logic so
);

    // A zero-length delay line has no meaning, so refuse to build one.
    if (DEPTH < 1) begin : g_bad_depth
        $error("siso_reg: DEPTH must be 1 or more");
    end

    // stage[0] is the input end and stage[DEPTH-1] is the output end.
    logic [DEPTH-1:0] stage;

    // Shift on every edge. While clear is low, every stage is filled and si is ignored.
    // The loop form avoids a negative slice when DEPTH is 1, which leaves a single D flop.
    always_ff @(posedge clk) begin
        if (!clear) begin
            stage <= {DEPTH{RESET_VALUE}};
        end else begin
            stage[0] <= si;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // The output comes straight from the last flop. There is no combinational path from si.
    assign so = stage[DEPTH-1];

endmodule

// File: tb/tb_siso_reg.sv
// Testbench for siso_reg. Four instances cover the default configuration,
// DEPTH=1, DEPTH=8 and RESET_VALUE=1. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, so both stay away from the
// active edge.
module tb_siso_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear4, si4, so4;
    logic clear1, si1, so1;
    logic clear8, si8, so8;
    logic clearr, sir, sor;

    siso_reg #(.DEPTH(4), .RESET_VALUE(1'b0)) u_d4 (
        .clk(clk), .clear(clear4), .si(si4), .so(so4));
    siso_reg #(.DEPTH(1), .RESET_VALUE(1'b0)) u_d1 (
        .clk(clk), .clear(clear1), .si(si1), .so(so1));
    siso_reg #(.DEPTH(8), .RESET_VALUE(1'b0)) u_d8 (
        .clk(clk), .clear(clear8), .si(si8), .so(so8));
    siso_reg #(.DEPTH(4), .RESET_VALUE(1'b1)) u_rv1 (
        .clk(clk), .clear(clearr), .si(sir), .so(sor));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic clear;
        logic si;
        logic exp_so;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the run is a fixed number of edges, so this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear4 = 1'b1; si4 = 1'b0;
        clear1 = 1'b1; si1 = 1'b0;
        clear8 = 1'b1; si8 = 1'b0;
        clearr = 1'b1; sir = 1'b0;

        // DEPTH=4 table: {clear, si, expected so after the edge}
        // reset with si=1: nothing may enter
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        // pattern 1,0,1,0 then zeros
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0});
        // reset, then continuous ones
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 1'b1, (i >= 3) ? 1'b1 : 1'b0});
        // reset mid-stream while full of ones, then zeros: nothing stale survives
        vecs.push_back('{1'b0, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b0, 1'b0});

        @(negedge clk);
        foreach (vecs[i]) begin
            clear4 = vecs[i].clear;
            si4    = vecs[i].si;
            edge_step();
            chk($sformatf("d4_vec%0d", i), so4, vecs[i].exp_so);
        end

        // The clear is synchronous, so asserting it between edges must not change so.
        clear4 = 1'b1; si4 = 1'b1;
        for (int i = 0; i < 4; i++) edge_step();
        chk("d4_full_ones", so4, 1'b1);
        clear4 = 1'b0;
        #3;
        chk("d4_clear_between_edges", so4, 1'b1);
        edge_step();
        chk("d4_clear_at_edge", so4, 1'b0);
        clear4 = 1'b1; si4 = 1'b0;

        // DEPTH=1: a single flop with one edge of delay
        clear1 = 1'b0; si1 = 1'b1;
        edge_step();
        chk("d1_reset", so1, 1'b0);
        clear1 = 1'b1;
        si1 = 1'b1; edge_step(); chk("d1_bit0", so1, 1'b1);
        si1 = 1'b0; edge_step(); chk("d1_bit1", so1, 1'b0);
        si1 = 1'b1; edge_step(); chk("d1_bit2", so1, 1'b1);
        si1 = 1'b0; edge_step(); chk("d1_tail", so1, 1'b0);

        // DEPTH=8: a single-cycle pulse appears 8 edges after capture, for one clock.
        clear8 = 1'b0; si8 = 1'b0;
        edge_step();
        chk("d8_reset", so8, 1'b0);
        clear8 = 1'b1; si8 = 1'b1;
        edge_step();
        chk("d8_edge1", so8, 1'b0);
        si8 = 1'b0;
        for (int e = 2; e <= 10; e++) begin
            edge_step();
            chk($sformatf("d8_edge%0d", e), so8, (e == 8) ? 1'b1 : 1'b0);
        end

        // RESET_VALUE=1: the reset fill is ones and drains after three edges.
        clearr = 1'b0; sir = 1'b0;
        edge_step();
        chk("rv1_reset", sor, 1'b1);
        clearr = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            edge_step();
            chk($sformatf("rv1_edge%0d", e), sor, (e <= 3) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/siso_reg.md
# siso_reg

Parameterised serial-in/serial-out shift register: one bit enters on `si` each clock and leaves on `so` exactly `DEPTH` clocks later, in the same order. It serves as a fixed-latency delay line or serial pipeline stage for single-bit streams between serial producers and consumers. State is `DEPTH` flip-flops. There is no parallel load and no parallel read.

## Interface
Parameters:
- `DEPTH`, default 4: number of stages and the latency in clocks. Legal range is 1 or more; elaboration fails for DEPTH < 1.
- `RESET_VALUE`, default 1'b0: value loaded into every stage during reset.

Ports, positional order clk, clear, si, so:
- `clk`, input, 1 bit: the single clock. All state updates on its rising edge.
- `clear`, input, 1 bit: reset, synchronous and active-low. While low at a rising edge, all stages load `RESET_VALUE`.
- `si`, input, 1 bit: serial data in, sampled on every rising edge when `clear` is high.
- `so`, output, 1 bit: serial data out. It is the last stage, driven directly from a flop with no combinational path from `si`.

## Operation
- Internal state: `stage[0..DEPTH-1]`. `stage[0]` is the input end and `stage[DEPTH-1]` is the output end.
- At a rising edge with `clear` = 0: every stage becomes `RESET_VALUE`. `si` is ignored.
- At a rising edge with `clear` = 1:
  - `stage[0]` takes `si`.
  - `stage[i]` takes `stage[i-1]` for i = 1..DEPTH-1.
  - All stages update simultaneously, non-blocking.
- `so` = `stage[DEPTH-1]` at all times.
- There is no enable: the register shifts on every edge outside reset.
- No hold, load or parallel-output mode exists.
- DEPTH = 1: the block degenerates to a single D flop with synchronous clear (`so` = `si` delayed one clock).
- X or Z on `si` propagates as-is. No sanitising. Reset overrides it.

## Timing
- Reset is synchronous. Asserting `clear` between edges has no effect until the next rising edge.
- `so` = `RESET_VALUE` starting from the first rising edge sampled with `clear` = 0.
- Before the first reset edge, `so` is undefined.
- Latency: a bit sampled on `si` at edge n appears on `so` immediately after edge n+DEPTH-1. It is held until just after edge n+DEPTH. This means exactly DEPTH edges of delay counting the sampling edge.
- Release from reset: at the first edge with `clear` = 1, `si` is captured. With DEPTH = 4, that bit reaches `so` after the 4th such edge. In between, `so` outputs the reset fill (`RESET_VALUE`), 3 clocks' worth.
- Reset mid-stream: the edge sampling `clear` = 0 discards all in-flight bits. `so` = `RESET_VALUE` after that edge.
  - Bits presented during reset are never shifted in.
  - Shifting resumes at the first edge with `clear` = 1.
- Throughput is 1 bit per clock with no bubbles.
- `so` changes only just after rising edges and is glitch-free.

## Test plan
- Reset check: use DEPTH=4 and a 10 ns clock. Hold `clear` = 0 for 2 edges with `si` = 1 -> `so` = 0 after the first reset edge and stays 0. No 1 enters.
- Pattern stream: release `clear` and drive `si` = 1,0,1,0 on edges 1-4, then 0 thereafter -> `so` = 0,0,0,1 after edges 1-4, then 0,1,0,0 after edges 5-8.
- Continuous ones: drive `si` = 1 for 8 edges after reset -> `so` = 0 after edges 1-3, then 1 from edge 4 onward.
- Reset mid-operation: fill the register with 1s, then drive `clear` = 0 for one edge -> `so` = 0 immediately after that edge. With `si` = 0 afterwards, `so` remains 0, proving no stale 1s survive.
- Parameter sweep:
  - DEPTH=1: `si` = 1,0,1 -> `so` = 1,0,1 one edge later.
  - DEPTH=8: a single 1 pulse appears on `so` exactly 8 edges after capture, for 1 clock.
- RESET_VALUE=1: reset with DEPTH=4, then drive `si` = 0 -> `so` = 1 after edges 1-3 and 0 from edge 4.
